// File: rtl/sequential_multiplier.sv
// Signed N x N multiplier using radix-2 Booth recoding, one iteration per clock.
// The result and Ready appear N+1 edges after the accepting edge.
module sequential_multiplier #(
  parameter int N = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [N-1:0]   Multiplicand,
  input  logic [N-1:0]   Multiplier,
  output logic [2*N-1:0] Product,
  output logic           Ready,
  input  logic           Start
);

  // Handshake: an operation is accepted on any rising edge where Ready=1 and
  // Start=1. Operands are sampled only on that edge. Ready stays low until
  // Product holds the new result, and Product then stays stable until the
  // next accepted Start.

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [N-1:0]  mcand;
  logic [N:0]    hi;
  logic [N-1:0]  lo;
  logic          qm1;
  logic [N:0]    sum;
  logic          done;

  // N Booth steps (count 0..N-1) are followed by one step that writes Product.
  assign done  = (count == CW'(N));
  assign Ready = (state == IDLE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = BUSY;
      BUSY:    if (done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The upper half is one bit wider than the operand, so that subtracting
  // the most negative multiplicand cannot overflow.
  always_comb begin
    sum = hi;
    case ({lo[0], qm1})
      2'b01:   sum = hi + {mcand[N-1], mcand};
      2'b10:   sum = hi - {mcand[N-1], mcand};
      default: sum = hi;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      qm1     <= 1'b0;
      count   <= '0;
      Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand <= Multiplicand;
            hi    <= '0;
            lo    <= Multiplier;
            qm1   <= 1'b0;
            count <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            Product <= {hi[N-1:0], lo};
          end else begin
            hi    <= {sum[N], sum[N:1]};
            lo    <= {sum[0], lo[N-1:1]};
            qm1   <= lo[0];
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Bench for sequential_multiplier: directed corners plus random operations,
// checked by a monitor against a plain-arithmetic signed product model.
module tb_sequential_multiplier;

  localparam int N = 8;
  localparam int W = 2 * N;

  logic           Clock = 1'b0;
  logic           Reset = 1'b0;
  logic [N-1:0]   Multiplicand = '0;
  logic [N-1:0]   Multiplier = '0;
  logic [W-1:0]   Product;
  logic           Ready;
  logic           Start = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           start_q[$];

  sequential_multiplier #(.N(N)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .Ready        (Ready),
    .Start        (Start)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [W-1:0] exp, input bit hold);
    int t;
    t = 0;
    @(negedge Clock);
    while (!Ready && t < 100) begin
      @(negedge Clock);
      t++;
    end
    if (!Ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: Ready still 0 after %0d cycles", t);
      return;
    end
    Multiplicand = a;
    Multiplier   = b;
    Start        = 1'b1;
    exp_q.push_back(exp);
    start_q.push_back(cyc + 1);
    @(posedge Clock);
    #1;
    check("accept_ready_low", W'(Ready), W'(0));
    @(negedge Clock);
    Multiplicand = N'($urandom);
    Multiplier   = N'($urandom);
    if (!hold) Start = 1'b0;
  endtask

  task automatic rand_op(input bit hold);
    logic [N-1:0] a, b;
    a = N'($urandom);
    b = N'($urandom);
    do_op(a, b, model(a, b), hold);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !Ready) && t < 200) begin
      @(negedge Clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results never appeared", exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic         ready_prev = 1'b1;
  logic [W-1:0] last_exp = '0;

  initial begin
    logic [W-1:0] e;
    int           s;
    forever begin
      @(posedge Clock);
      #1;
      if (!Reset) begin
        last_exp   = '0;
        ready_prev = Ready;
      end else begin
        if (Ready && !ready_prev) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: product %h with no operation pending", Product);
          end else begin
            e = exp_q.pop_front();
            s = start_q.pop_front();
            check("product", Product, e);
            check("latency", W'(cyc - s), W'(N + 1));
            last_exp = e;
          end
        end else if (Ready && ready_prev) begin
          check("idle_hold", Product, last_exp);
        end
        ready_prev = Ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge Clock);
    check("reset_ready", W'(Ready), W'(1));
    check("reset_product", Product, W'(0));
    Reset = 1'b1;
    repeat (6) @(negedge Clock);

    do_op(8'd3, 8'd5, 16'h000F, 1'b0);
    do_op(8'hFF, 8'hFF, 16'h0001, 1'b0);
    do_op(8'h80, 8'h80, 16'h4000, 1'b0);
    do_op(8'h80, 8'h7F, 16'hC080, 1'b0);
    do_op(8'h7F, 8'h7F, 16'h3F01, 1'b0);
    do_op(8'h00, 8'hB3, 16'h0000, 1'b0);
    drain();
    repeat (3) @(negedge Clock);

    // Start and new operands while busy must not disturb the running operation.
    do_op(8'd7, 8'd6, 16'h002A, 1'b0);
    repeat (3) @(negedge Clock);
    Multiplicand = N'($urandom);
    Multiplier   = N'($urandom);
    Start        = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    drain();
    repeat (2) @(negedge Clock);

    // Start held high: back-to-back operations.
    for (int i = 0; i < 5; i++) rand_op(i != 4);
    drain();

    for (int i = 0; i < 1500; i++) rand_op(1'($urandom_range(0, 1)));
    rand_op(1'b0);
    drain();

    // Reset four cycles into an operation aborts it.
    rand_op(1'b0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("abort_ready", W'(Ready), W'(1));
    check("abort_product", Product, W'(0));
    @(posedge Clock);
    #2;
    exp_q.delete();
    start_q.delete();
    @(negedge Clock);
    Reset = 1'b1;
    do_op(8'hFE, 8'h03, 16'hFFFA, 1'b0);
    drain();
    repeat (4) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sequential_multiplier.md
SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

Interface
REQ-001 Parameter N SHALL be the operand width in bits, default 8 (legal range 2..32).
REQ-002 Port Clock SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port Reset SHALL be an input, 1 bit wide, asynchronous and active-low (0 = reset).
REQ-004 Port Multiplicand SHALL be an input, N bits wide: signed two's-complement operand A.
REQ-005 Port Multiplier SHALL be an input, N bits wide: signed two's-complement operand B.
REQ-006 Port Product SHALL be an output, 2N bits wide: signed two's-complement result A*B.
REQ-007 Port Ready SHALL be an output, 1 bit wide: 1 = idle, Product valid, Start accepted.
REQ-008 Port Start SHALL be an input, 1 bit wide: request a multiply; sampled on a rising edge while Ready=1.
REQ-009 Ports SHALL be declared in this order: Clock, Reset, Multiplicand, Multiplier, Product, Ready, Start.

Function
REQ-010 The block SHALL compute the exact signed product sign-extended to 2N bits; no overflow is possible. Example: -128*-128 = 16'h4000.
REQ-011 The block SHALL be an FSM with states IDLE and BUSY; IDLE drives Ready=1 and BUSY drives Ready=0.
REQ-012 In IDLE, Start=1 at a rising edge SHALL latch Multiplicand and Multiplier into internal registers, clear the accumulator and iteration counter, and move the FSM to BUSY.
REQ-013 Ready SHALL be 0 from the edge that accepts Start; a Start pulse one cycle wide SHALL be sufficient.
REQ-014 BUSY SHALL perform exactly N iterations, one per clock, of radix-2 Booth recoding or equivalent signed shift-add with final sign correction.
REQ-015 After the Nth iteration edge the FSM SHALL return to IDLE; Ready=1 and the final Product SHALL both become visible N+1 rising edges after the Start edge (9 for N=8), well inside the 2N+4 cycle bound.
REQ-016 Product SHALL be registered; during BUSY it SHALL either hold the previous result or show partial values, and it SHALL hold the final value stable throughout IDLE until the next accepted Start.
REQ-017 Start and operand changes during BUSY SHALL be ignored; the operands are only used as latched at acceptance.
REQ-018 If Start is held high continuously, a new operation SHALL be accepted at the first edge in IDLE, so Ready is high for exactly one cycle between operations.
REQ-019 Operand inputs SHALL only be sampled at the accepting edge; they need not be stable at any other time.

Reset
REQ-020 Reset=0 SHALL asynchronously force IDLE, Ready=1, Product=0, and clear the counter and operand registers.
REQ-021 Reset asserted during BUSY SHALL abort the operation with no residual effect.
REQ-022 After Reset returns to 1, the first rising edge with Start=1 SHALL be accepted.

Verification
REQ-023 Reset pulse, then no Start -> Ready=1 and Product=16'h0000 held indefinitely.
REQ-024 N=8, A=3, B=5, Start pulse -> Ready=0 one cycle later; Ready=1 with Product=16'h000F exactly 9 edges after the Start edge.
REQ-025 Sign corners: -1*-1 gives 16'h0001; -128*-128 gives 16'h4000; -128*127 gives 16'hC080; 127*127 gives 16'h3F01; 0*-77 gives 16'h0000.
REQ-026 Exhaustive sweep of all 65536 (A,B) pairs, with Start issued at each Ready -> every Product equals sign-extended A*B and no run exceeds 2N+4 cycles.
REQ-027 Start with A=7, B=6, then change the operands and pulse Start mid-BUSY -> result is 16'h002A, and the extra Start does not restart the operation.
REQ-028 Reset asserted 4 cycles into BUSY -> Ready=1 and Product=0 immediately; a following A=-2, B=3 operation gives 16'hFFFA.
